// File: rtl/cdb_arbiter_pkg.sv
// Shared types and defaults for the common data bus arbiter and its source FIFOs.
package cdb_arbiter_pkg;

  localparam int CDB_ROB_ID_W   = 4;
  localparam int CDB_DATA_W     = 32;
  localparam int CDB_FIFO_DEPTH = 4;

  typedef enum logic {
    CDB_SRC_ALU = 1'b0,
    CDB_SRC_LSB = 1'b1
  } cdb_src_e;

  function automatic cdb_src_e other_src(input cdb_src_e s);
    return (s == CDB_SRC_ALU) ? CDB_SRC_LSB : CDB_SRC_ALU;
  endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO feeding the CDB arbiter; push/pop are pre-qualified by the top.
module cdb_src_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int ROB_ID_W   = CDB_ROB_ID_W,
  parameter int DATA_W     = CDB_DATA_W,
  parameter int FIFO_DEPTH = CDB_FIFO_DEPTH,
  localparam int PTR_W     = $clog2(FIFO_DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                flush,
  input  logic                push,
  input  logic [ROB_ID_W-1:0] push_dest,
  input  logic [DATA_W-1:0]   push_value,
  input  logic                pop,
  output logic [ROB_ID_W-1:0] head_dest,
  output logic [DATA_W-1:0]   head_value,
  output logic                empty,
  output logic [CNT_W-1:0]    count
);

  logic [ROB_ID_W-1:0] dest_mem  [FIFO_DEPTH];
  logic [DATA_W-1:0]   value_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (rdy) begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Storage carries no reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (rst && rdy && !flush && push) begin
      dest_mem[wr_ptr]  <= push_dest;
      value_mem[wr_ptr] <= push_value;
    end
  end

  assign head_dest  = dest_mem[rd_ptr];
  assign head_value = value_mem[rd_ptr];
  assign empty      = (count == '0);

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the single CDB broadcast slot between ALU and LS buffer results.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int ROB_ID_W   = CDB_ROB_ID_W,
  parameter int DATA_W     = CDB_DATA_W,
  parameter int FIFO_DEPTH = CDB_FIFO_DEPTH,
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                flush,
  input  logic [ROB_ID_W-1:0] dest_from_alu,
  input  logic [DATA_W-1:0]   value_from_alu,
  output logic                ready_to_alu,
  input  logic [ROB_ID_W-1:0] dest_from_lsb,
  input  logic [DATA_W-1:0]   value_from_lsb,
  output logic                ready_to_lsb,
  output logic [ROB_ID_W-1:0] dest_to_cdb,
  output logic [DATA_W-1:0]   value_to_cdb,
  output logic                almost_full
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(FIFO_DEPTH - 1);

  logic [ROB_ID_W-1:0] alu_head_dest, lsb_head_dest;
  logic [DATA_W-1:0]   alu_head_value, lsb_head_value;
  logic                alu_empty, lsb_empty;
  logic [CNT_W-1:0]    alu_count, lsb_count;
  logic                alu_acc, lsb_acc, alu_cand, lsb_cand;
  logic                alu_win, lsb_win, alu_push, lsb_push, alu_pop, lsb_pop;
  logic [ROB_ID_W-1:0] alu_cand_dest, lsb_cand_dest;
  logic [DATA_W-1:0]   alu_cand_value, lsb_cand_value;

  cdb_src_e            rr_p1;
  logic [ROB_ID_W-1:0] dest_p1;
  logic [DATA_W-1:0]   value_p1;

  cdb_src_fifo #(.ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .push(alu_push), .push_dest(dest_from_alu), .push_value(value_from_alu), .pop(alu_pop),
    .head_dest(alu_head_dest), .head_value(alu_head_value), .empty(alu_empty), .count(alu_count)
  );

  cdb_src_fifo #(.ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_lsb_fifo (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .push(lsb_push), .push_dest(dest_from_lsb), .push_value(value_from_lsb), .pop(lsb_pop),
    .head_dest(lsb_head_dest), .head_value(lsb_head_value), .empty(lsb_empty), .count(lsb_count)
  );

  // Acceptance uses the pre-edge count, so a full FIFO refuses even while popping.
  assign ready_to_alu = rst & rdy & ~flush & (alu_count < FULL_CNT);
  assign ready_to_lsb = rst & rdy & ~flush & (lsb_count < FULL_CNT);
  assign almost_full  = (alu_count >= AF_CNT) | (lsb_count >= AF_CNT);

  assign alu_acc = ready_to_alu & (dest_from_alu != '0);
  assign lsb_acc = ready_to_lsb & (dest_from_lsb != '0);

  assign alu_cand       = ~alu_empty | alu_acc;
  assign lsb_cand       = ~lsb_empty | lsb_acc;
  assign alu_cand_dest  = alu_empty ? dest_from_alu  : alu_head_dest;
  assign alu_cand_value = alu_empty ? value_from_alu : alu_head_value;
  assign lsb_cand_dest  = lsb_empty ? dest_from_lsb  : lsb_head_dest;
  assign lsb_cand_value = lsb_empty ? value_from_lsb : lsb_head_value;

  assign alu_win = alu_cand & (~lsb_cand | (rr_p1 == CDB_SRC_ALU));
  assign lsb_win = lsb_cand & ~alu_win;

  // A bypass winner never enters its FIFO; everything else accepted is queued.
  assign alu_pop  = alu_win & ~alu_empty;
  assign lsb_pop  = lsb_win & ~lsb_empty;
  assign alu_push = alu_acc & ~(alu_win & alu_empty);
  assign lsb_push = lsb_acc & ~(lsb_win & lsb_empty);

  // ---- stage p1: registered CDB broadcast ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_p1    <= CDB_SRC_ALU;
      dest_p1  <= '0;
      value_p1 <= '0;
    end else if (rdy) begin
      if (flush) begin
        rr_p1   <= CDB_SRC_ALU;
        dest_p1 <= '0;
      end else begin
        if (alu_cand && lsb_cand) rr_p1 <= other_src(rr_p1);
        if (alu_win) begin
          dest_p1  <= alu_cand_dest;
          value_p1 <= alu_cand_value;
        end else if (lsb_win) begin
          dest_p1  <= lsb_cand_dest;
          value_p1 <= lsb_cand_value;
        end else begin
          dest_p1  <= '0;
        end
      end
    end
  end

  assign dest_to_cdb  = dest_p1;
  assign value_to_cdb = value_p1;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios then random traffic against a queue-based reference.
module tb_cdb_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, rdy, flush;
  logic [3:0]  dest_from_alu, dest_from_lsb;
  logic [31:0] value_from_alu, value_from_lsb;
  logic        ready_to_alu, ready_to_lsb, almost_full;
  logic [3:0]  dest_to_cdb;
  logic [31:0] value_to_cdb;

  always #5 clk = ~clk;

  cdb_arbiter #(.ROB_ID_W(4), .DATA_W(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .dest_from_alu(dest_from_alu), .value_from_alu(value_from_alu), .ready_to_alu(ready_to_alu),
    .dest_from_lsb(dest_from_lsb), .value_from_lsb(value_from_lsb), .ready_to_lsb(ready_to_lsb),
    .dest_to_cdb(dest_to_cdb), .value_to_cdb(value_to_cdb), .almost_full(almost_full)
  );

  typedef struct {
    logic [3:0]  d;
    logic [31:0] v;
  } ent_t;

  ent_t        aq[$];
  ent_t        lq[$];
  bit          m_rr;
  logic [3:0]  m_dest;
  logic [31:0] m_val;
  bit          m_init = 0;
  bit          acc_a, acc_l;
  bit          saw_full, saw_af;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] da, input logic [31:0] va,
                       input logic [3:0] dl, input logic [31:0] vl);
    dest_from_alu  = da;
    value_from_alu = va;
    dest_from_lsb  = dl;
    value_from_lsb = vl;
  endtask

  // One clock: check handshake outputs mid-cycle, advance the reference, check the CDB.
  task automatic step();
    bit   ea, el, ca, cl, ae, le, win_a, win_l;
    ent_t e;
    @(negedge clk);
    ea = rst && rdy && !flush && (aq.size() < DEPTH);
    el = rst && rdy && !flush && (lq.size() < DEPTH);
    chk("ready_to_alu", 32'(ready_to_alu), 32'(ea));
    chk("ready_to_lsb", 32'(ready_to_lsb), 32'(el));
    if (m_init)
      chk("almost_full", 32'(almost_full),
          32'((aq.size() >= DEPTH - 1) || (lq.size() >= DEPTH - 1)));
    if (rst && rdy && !flush && !ready_to_alu) saw_full = 1;
    if (almost_full === 1'b1) saw_af = 1;
    @(posedge clk);
    acc_a = 0;
    acc_l = 0;
    if (!rst) begin
      aq.delete(); lq.delete();
      m_rr = 0; m_dest = '0; m_val = '0; m_init = 1;
    end else if (rdy) begin
      if (flush) begin
        aq.delete(); lq.delete();
        m_rr = 0; m_dest = '0;
      end else begin
        acc_a = ea && (dest_from_alu != 0);
        acc_l = el && (dest_from_lsb != 0);
        ae = (aq.size() == 0);
        le = (lq.size() == 0);
        ca = !ae || acc_a;
        cl = !le || acc_l;
        if (ca && cl) begin
          win_a = (m_rr == 0);
          m_rr  = !m_rr;
        end else begin
          win_a = ca;
        end
        win_l = cl && !win_a;
        if (win_a) begin
          if (ae) e = '{dest_from_alu, value_from_alu};
          else    e = aq.pop_front();
          m_dest = e.d; m_val = e.v;
        end else if (win_l) begin
          if (le) e = '{dest_from_lsb, value_from_lsb};
          else    e = lq.pop_front();
          m_dest = e.d; m_val = e.v;
        end else begin
          m_dest = '0;
        end
        if (acc_a && !(win_a && ae)) aq.push_back('{dest_from_alu, value_from_alu});
        if (acc_l && !(win_l && le)) lq.push_back('{dest_from_lsb, value_from_lsb});
      end
    end
    #1;
    if (m_init) begin
      chk("dest_to_cdb", 32'(dest_to_cdb), 32'(m_dest));
      if (m_dest != 0) chk("value_to_cdb", value_to_cdb, m_val);
    end
  endtask

  initial begin
    int          next_a, nl;
    logic [31:0] got_v[$];
    logic [3:0]  got_d[$];
    bit          a_pend, l_pend;
    logic [3:0]  a_d, l_d;
    logic [31:0] a_v, l_v;

    rst = 0; rdy = 1; flush = 0;
    drive(4'd5, 32'h55, 0, 0);
    step(); step();
    chk("reset_dest", 32'(dest_to_cdb), 0);
    chk("reset_value", value_to_cdb, 0);
    chk("reset_ready_alu", 32'(ready_to_alu), 0);
    rst = 1;
    drive(0, 0, 0, 0);
    step(); chk("post_reset_idle", 32'(dest_to_cdb), 0);
    step(); chk("post_reset_idle2", 32'(dest_to_cdb), 0);

    drive(4'd3, 32'h11, 0, 0);
    step(); chk("bypass_dest", 32'(dest_to_cdb), 3); chk("bypass_value", value_to_cdb, 32'h11);
    drive(0, 0, 0, 0);
    step(); chk("bypass_one_cycle", 32'(dest_to_cdb), 0);

    drive(4'd4, 32'hA, 4'd7, 32'hB);
    step(); chk("contend1_first", 32'(dest_to_cdb), 4);
    drive(0, 0, 0, 0);
    step(); chk("contend1_second", 32'(dest_to_cdb), 7); chk("contend1_val", value_to_cdb, 32'hB);
    drive(4'd5, 32'h5, 4'd6, 32'h6);
    step(); chk("contend2_first", 32'(dest_to_cdb), 6);
    drive(0, 0, 0, 0);
    step(); chk("contend2_second", 32'(dest_to_cdb), 5);
    step(); chk("contend2_idle", 32'(dest_to_cdb), 0);

    // Both sources stream continuously so the ALU FIFO fills up.
    saw_full = 0; saw_af = 0; next_a = 1; nl = 0;
    for (int c = 0; c < 60; c++) begin
      drive((next_a <= 12) ? 4'(next_a) : 4'd0, 32'(next_a),
            (next_a <= 12) ? 4'(13 + nl % 3) : 4'd0, 32'h100 + 32'(nl));
      step();
      if (acc_a) next_a++;
      if (acc_l) nl++;
      if (dest_to_cdb != 0 && value_to_cdb < 32'h100) begin
        got_d.push_back(dest_to_cdb);
        got_v.push_back(value_to_cdb);
      end
    end
    chk("stream_saw_full", 32'(saw_full), 1);
    chk("stream_saw_af", 32'(saw_af), 1);
    chk("stream_alu_count", 32'(got_v.size()), 12);
    for (int i = 0; i < got_v.size() && i < 12; i++) begin
      chk("stream_alu_order", got_v[i], 32'(i + 1));
      chk("stream_alu_tag", 32'(got_d[i]), 32'(i + 1));
    end

    drive(4'd1, 32'h21, 4'd10, 32'h31); step();
    drive(4'd2, 32'h22, 4'd11, 32'h32); step();
    drive(4'd3, 32'h23, 0, 0);          step();
    drive(0, 0, 0, 0);
    flush = 1; step(); flush = 0;
    chk("flush_dest", 32'(dest_to_cdb), 0);
    for (int i = 0; i < 3; i++) begin
      step(); chk("flush_no_stale", 32'(dest_to_cdb), 0);
    end
    drive(4'd9, 32'h99, 0, 0);
    step(); chk("after_flush_tag9", 32'(dest_to_cdb), 9);
    drive(0, 0, 0, 0); step();

    drive(4'd1, 32'h41, 4'd2, 32'h42); step();
    drive(4'd3, 32'h43, 4'd4, 32'h44); step();
    drive(0, 0, 0, 0);
    rdy = 0;
    for (int i = 0; i < 3; i++) begin
      step(); chk("stall_ready_alu", 32'(ready_to_alu), 0);
    end
    rdy = 1;
    for (int i = 0; i < 5; i++) step();
    chk("stall_drained", 32'(dest_to_cdb), 0);

    a_pend = 0; l_pend = 0;
    a_d = '0; l_d = '0; a_v = '0; l_v = '0;
    for (int c = 0; c < 600; c++) begin
      if (!a_pend && ($urandom_range(0, 99) < 60)) begin
        a_pend = 1; a_d = 4'($urandom_range(1, 15)); a_v = $urandom;
      end
      if (!l_pend && ($urandom_range(0, 99) < 60)) begin
        l_pend = 1; l_d = 4'($urandom_range(1, 15)); l_v = $urandom;
      end
      rdy   = ($urandom_range(0, 99) < 90);
      flush = ($urandom_range(0, 99) < 3);
      rst   = ($urandom_range(0, 999) >= 4);
      drive(a_pend ? a_d : 4'd0, a_v, l_pend ? l_d : 4'd0, l_v);
      step();
      if (acc_a) a_pend = 0;
      if (acc_l) l_pend = 0;
      if (flush && rdy) begin a_pend = 0; l_pend = 0; end
    end
    rst = 1; rdy = 1; flush = 0;
    drive(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step();
    chk("final_idle", 32'(dest_to_cdb), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
